// File: rtl/orion_pkg.sv
// Shared types and constants for the digit-memory game datapath.
// The playback sequencer imports the state encoding and the display blank code from here.
package orion_pkg;

    // IDLE wait start | FETCH address RAM   | SHOW digit on display | GAP blank between digits
    // IN_LOAD address | IN_WAIT await entry | PASS pass pulse       | FAIL fail pulse
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW,
        GAP,
        IN_LOAD,
        IN_WAIT,
        PASS,
        FAIL
    } seq_state_e;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         MAX_SEQ     = 32;

endpackage

// File: rtl/seq_playback_ctrl.sv
// Plays a stored digit sequence on the display and then checks the player's entries
// against the same RAM addresses, reporting a one-cycle pass or fail pulse.
module seq_playback_ctrl
    import orion_pkg::*;
#(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 4,
    parameter logic [DATA_W-1:0] BLANK  = BLANK_DIGIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              tick_2s,
    input  logic              tick_100ms,
    output logic              two_sec_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] disp_digit,
    input  logic              entry_valid,
    input  logic [DATA_W-1:0] entry_digit,
    output logic              timer_en,
    input  logic              timeout,
    output logic              busy,
    output logic [ADDR_W:0]   correct_cnt,
    output logic              round_pass,
    output logic              round_fail
);

    // The length cap is the smaller of the RAM depth and the game's sequence limit.
    localparam int              LEN_CAP = ((2**ADDR_W) < MAX_SEQ) ? (2**ADDR_W) : MAX_SEQ;
    localparam logic [ADDR_W:0] LEN_MAX = LEN_CAP[ADDR_W:0];
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    seq_state_e        state_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] disp_q;
    logic              two_sec_en_q;
    logic              timer_en_q;
    logic              busy_q;
    logic              pass_q;
    logic              fail_q;
    logic              show_first_q;

    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   idx_d;
    logic [ADDR_W:0]   cnt_d;
    logic              idx_last;

    always_comb begin
        len_d = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
        idx_d = idx_q + LEN_ONE;
        cnt_d = cnt_q + LEN_ONE;
        idx_last = (idx_q == (len_q - LEN_ONE));
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            disp_q       <= BLANK;
            two_sec_en_q <= 1'b0;
            timer_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            show_first_q <= 1'b0;
        end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        ram_addr_q <= '0;
                        busy_q     <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= PASS;
                        end else begin
                            len_q   <= len_d;
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    ram_addr_q   <= idx_q[ADDR_W-1:0];
                    show_first_q <= 1'b1;
                    state_q      <= SHOW;
                end
                SHOW: begin
                    if (show_first_q) begin
                        disp_q       <= ram_rdata;
                        two_sec_en_q <= 1'b1;
                        show_first_q <= 1'b0;
                    end else if (tick_2s) begin
                        disp_q       <= BLANK;
                        two_sec_en_q <= 1'b0;
                        state_q      <= GAP;
                    end
                end
                GAP: begin
                    if (tick_100ms) begin
                        if (idx_last) begin
                            idx_q      <= '0;
                            ram_addr_q <= '0;
                            timer_en_q <= 1'b1;
                            state_q    <= IN_LOAD;
                        end else begin
                            idx_q      <= idx_d;
                            ram_addr_q <= idx_d[ADDR_W-1:0];
                            state_q    <= FETCH;
                        end
                    end
                end
                IN_LOAD: begin
                    if (timeout) begin
                        state_q <= FAIL;
                    end else begin
                        ram_addr_q <= idx_q[ADDR_W-1:0];
                        state_q    <= IN_WAIT;
                    end
                end
                IN_WAIT: begin
                    if (timeout) begin
                        state_q <= FAIL;
                    end else if (entry_valid) begin
                        if (entry_digit == ram_rdata) begin
                            cnt_q <= cnt_d;
                            if (idx_last) begin
                                state_q <= PASS;
                            end else begin
                                idx_q      <= idx_d;
                                ram_addr_q <= idx_d[ADDR_W-1:0];
                                state_q    <= IN_LOAD;
                            end
                        end else begin
                            state_q <= FAIL;
                        end
                    end
                end
                PASS: begin
                    pass_q     <= 1'b1;
                    timer_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                FAIL: begin
                    fail_q     <= 1'b1;
                    timer_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign two_sec_en  = two_sec_en_q;
    assign ram_addr    = ram_addr_q;
    assign disp_digit  = disp_q;
    assign timer_en    = timer_en_q;
    assign busy        = busy_q;
    assign correct_cnt = cnt_q;
    assign round_pass  = pass_q;
    assign round_fail  = fail_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Directed bench for seq_playback_ctrl: RAM and two-second timer models around the DUT,
// playback capture, entry rounds, timeout/abort races and length boundaries.
module tb_seq_playback_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] seq_len;
    logic       tick_2s;
    logic       tick_100ms;
    logic       two_sec_en;
    logic [4:0] ram_addr;
    logic [3:0] ram_rdata;
    logic [3:0] disp_digit;
    logic       entry_valid;
    logic [3:0] entry_digit;
    logic       timer_en;
    logic       timeout;
    logic       busy;
    logic [5:0] correct_cnt;
    logic       round_pass;
    logic       round_fail;

    seq_playback_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .seq_len     (seq_len),
        .tick_2s     (tick_2s),
        .tick_100ms  (tick_100ms),
        .two_sec_en  (two_sec_en),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .disp_digit  (disp_digit),
        .entry_valid (entry_valid),
        .entry_digit (entry_digit),
        .timer_en    (timer_en),
        .timeout     (timeout),
        .busy        (busy),
        .correct_cnt (correct_cnt),
        .round_pass  (round_pass),
        .round_fail  (round_fail)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [32];
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    // Timer model: tick_2s after p2 enabled cycles, tick_100ms free-running every p1 cycles.
    int p2 = 200;
    int p1 = 10;
    int cnt2 = 0;
    int cnt1 = 0;
    always @(negedge clk) begin
        if (two_sec_en === 1'b1) begin
            cnt2++;
            if (cnt2 >= p2) begin
                tick_2s = 1'b1;
                cnt2 = 0;
            end else begin
                tick_2s = 1'b0;
            end
        end else begin
            cnt2 = 0;
            tick_2s = 1'b0;
        end
        cnt1++;
        if (cnt1 >= p1) begin
            tick_100ms = 1'b1;
            cnt1 = 0;
        end else begin
            tick_100ms = 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_round(input logic [5:0] len);
        @(negedge clk);
        seq_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d, input logic to);
        repeat (3) @(negedge clk);
        entry_digit = d;
        entry_valid = 1'b1;
        timeout = to;
        @(negedge clk);
        entry_valid = 1'b0;
        timeout = 1'b0;
    endtask

    int shown[$];
    int dur[$];
    int en_err;
    int wraps;
    int max_addr;
    int first_show;
    int saw_in;

    task automatic run_playback(input int budget);
        int cyc = 0;
        int run = 0;
        int prev_addr;
        logic [3:0] prev = 4'hF;
        shown.delete();
        dur.delete();
        en_err = 0;
        wraps = 0;
        max_addr = 0;
        first_show = 0;
        saw_in = 0;
        prev_addr = int'(ram_addr);
        while (cyc < budget && saw_in == 0) begin
            @(negedge clk);
            cyc++;
            if (timer_en === 1'b1) begin
                saw_in = 1;
            end else begin
                if (two_sec_en !== (disp_digit != 4'hF)) en_err++;
                if (int'(ram_addr) < prev_addr) wraps++;
                prev_addr = int'(ram_addr);
                if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
                if (disp_digit != 4'hF) begin
                    if (prev == 4'hF) begin
                        shown.push_back(int'(disp_digit));
                        if (first_show == 0) first_show = cyc;
                        run = 0;
                    end
                    run++;
                end else if (prev != 4'hF) begin
                    dur.push_back(run);
                end
                prev = disp_digit;
            end
        end
    endtask

    initial begin
        int seen;
        int pulses;
        int busy_hi;
        int bad;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seq_len = '0;
        entry_valid = 1'b0;
        entry_digit = '0;
        timeout = 1'b0;
        tick_2s = 1'b0;
        tick_100ms = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i % 15);
        mem[0] = 4'd7;
        mem[1] = 4'd2;
        mem[2] = 4'd9;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_disp", disp_digit, 15);
        check_eq("rst_addr", ram_addr, 0);
        check_eq("rst_2s_en", two_sec_en, 0);
        check_eq("rst_timer_en", timer_en, 0);
        check_eq("rst_cnt", correct_cnt, 0);
        check_eq("rst_pass", round_pass, 0);
        check_eq("rst_fail", round_fail, 0);
        rst = 1'b0;

        // Round 1: playback 7,2,9 with 200-cycle digits, then a correct entry sequence.
        start_round(6'd3);
        check_eq("r1_busy", busy, 1);
        run_playback(3000);
        check_eq("r1_reached_input", saw_in, 1);
        check_eq("r1_latency", first_show, 2);
        check_eq("r1_ndigits", shown.size(), 3);
        check_eq("r1_digit0", shown[0], 7);
        check_eq("r1_digit1", shown[1], 2);
        check_eq("r1_digit2", shown[2], 9);
        check_eq("r1_ndur", dur.size(), 3);
        check_eq("r1_dur0", dur[0], 200);
        check_eq("r1_dur1", dur[1], 200);
        check_eq("r1_dur2", dur[2], 200);
        check_eq("r1_en_tracks_disp", en_err, 0);
        enter(4'd7, 1'b0);
        check_eq("r1_cnt1", correct_cnt, 1);
        enter(4'd2, 1'b0);
        check_eq("r1_cnt2", correct_cnt, 2);
        enter(4'd9, 1'b0);
        check_eq("r1_cnt3", correct_cnt, 3);
        check_eq("r1_pass_early", round_pass, 0);
        @(negedge clk);
        check_eq("r1_pass", round_pass, 1);
        check_eq("r1_no_fail", round_fail, 0);
        check_eq("r1_busy_after", busy, 0);
        check_eq("r1_timer_off", timer_en, 0);
        @(negedge clk);
        check_eq("r1_pass_one_cycle", round_pass, 0);
        check_eq("r1_cnt_held", correct_cnt, 3);

        // Round 2: wrong second entry.
        p2 = 20;
        start_round(6'd3);
        check_eq("r2_cnt_cleared", correct_cnt, 0);
        run_playback(2000);
        check_eq("r2_reached_input", saw_in, 1);
        enter(4'd7, 1'b0);
        check_eq("r2_cnt1", correct_cnt, 1);
        enter(4'd4, 1'b0);
        check_eq("r2_fail_early", round_fail, 0);
        @(negedge clk);
        check_eq("r2_fail", round_fail, 1);
        check_eq("r2_no_pass", round_pass, 0);
        check_eq("r2_cnt", correct_cnt, 1);
        check_eq("r2_timer_off", timer_en, 0);
        @(negedge clk);
        check_eq("r2_fail_one_cycle", round_fail, 0);

        // Round 3: timeout coincides with the final correct entry.
        start_round(6'd3);
        run_playback(2000);
        check_eq("r3_reached_input", saw_in, 1);
        enter(4'd7, 1'b0);
        enter(4'd2, 1'b0);
        enter(4'd9, 1'b1);
        @(negedge clk);
        check_eq("r3_fail", round_fail, 1);
        check_eq("r3_no_pass", round_pass, 0);
        check_eq("r3_cnt", correct_cnt, 2);

        // Round 4: abort together with start while digit 2 is on display.
        start_round(6'd3);
        seen = 0;
        for (int i = 0; i < 1000 && seen == 0; i++) begin
            @(negedge clk);
            if (disp_digit == 4'd2) seen = 1;
        end
        check_eq("r4_digit2_seen", seen, 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_eq("r4_busy", busy, 0);
        check_eq("r4_disp", disp_digit, 15);
        check_eq("r4_2s_en", two_sec_en, 0);
        check_eq("r4_cnt", correct_cnt, 0);
        pulses = 0;
        busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (round_pass || round_fail) pulses++;
            if (busy) busy_hi++;
        end
        check_eq("r4_no_pulse", pulses, 0);
        check_eq("r4_stays_idle", busy_hi, 0);

        // Round 5: empty sequence passes straight away.
        start_round(6'd0);
        check_eq("r5_busy", busy, 1);
        check_eq("r5_pass_early", round_pass, 0);
        @(negedge clk);
        check_eq("r5_pass", round_pass, 1);
        check_eq("r5_busy_after", busy, 0);
        check_eq("r5_addr", ram_addr, 0);
        check_eq("r5_disp", disp_digit, 15);

        // Rounds 6/7: full-depth and over-length sequences.
        p2 = 6;
        p1 = 3;
        mem[0] = 4'd0;
        mem[1] = 4'd1;
        mem[2] = 4'd2;
        start_round(6'd32);
        run_playback(5000);
        check_eq("r6_reached_input", saw_in, 1);
        check_eq("r6_ndigits", shown.size(), 32);
        bad = 0;
        foreach (shown[i]) if (shown[i] != i % 15) bad++;
        check_eq("r6_digit_errors", bad, 0);
        check_eq("r6_wraps", wraps, 0);
        check_eq("r6_max_addr", max_addr, 31);
        check_eq("r6_en_tracks_disp", en_err, 0);
        check_eq("r6_input_addr", ram_addr, 0);
        do_abort();
        check_eq("r6_abort_busy", busy, 0);
        check_eq("r6_abort_timer", timer_en, 0);

        start_round(6'd40);
        run_playback(5000);
        check_eq("r7_reached_input", saw_in, 1);
        check_eq("r7_clamped_ndigits", shown.size(), 32);
        check_eq("r7_wraps", wraps, 0);
        check_eq("r7_max_addr", max_addr, 31);
        do_abort();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
- Sequences one game round on the digit RAM datapath. It plays the stored random digits back on the random-number display, one digit per 2 s pulse with a 100 ms blank gap between digits. It then walks the same RAM addresses and checks the player's entries against them.
- Sits between the game controller (start, length, abort, pass/fail), the digit RAM (read port), the two-second timer and the two-digit countdown timer.

Parameters:
- ADDR_W, 5, RAM address width; maximum sequence length is 2**ADDR_W.
- DATA_W, 4, digit width.
- BLANK, 4'hF, display code for a blank digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle round start pulse from the game controller
- abort  in  1  logout or abandon; forces the block to IDLE
- seq_len  in  ADDR_W+1  number of digits in the round, 0..32
- tick_2s  in  1  one-cycle pulse from the two-second timer
- tick_100ms  in  1  one-cycle pulse from the two-second timer
- two_sec_en  out  1  enable for the two-second timer
- ram_addr  out  ADDR_W  RAM read address
- ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid 1 cycle after ram_addr
- disp_digit  out  DATA_W  digit to the display decoder
- entry_valid  in  1  shaped button pulse marking a player entry
- entry_digit  in  DATA_W  the player's digit
- timer_en  out  1  enable for the countdown timer during input
- timeout  in  1  countdown expired
- busy  out  1  high in every state except IDLE
- correct_cnt  out  ADDR_W+1  number of entries matched so far
- round_pass  out  1  one-cycle pulse
- round_fail  out  1  one-cycle pulse

Behaviour:
- Reset values (also applied on abort): state IDLE, idx=0, ram_addr=0, disp_digit=BLANK, two_sec_en=0, timer_en=0, busy=0, correct_cnt=0, round_pass=0, round_fail=0.
- State IDLE:
  - start with seq_len=0 goes to PASS.
  - start with seq_len>0 latches len and sets idx=0, then goes to FETCH.
  - start while busy is ignored.
- State FETCH: drive ram_addr=idx; next cycle go to SHOW.
- State SHOW:
  - First cycle: disp_digit <= ram_rdata (registered); two_sec_en=1.
  - On tick_2s: two_sec_en drops to 0, disp_digit=BLANK, go to GAP.
- State GAP:
  - On tick_100ms: if idx==len-1, go to IN_LOAD with idx=0; otherwise idx+1 and go to FETCH.
  - two_sec_en stays low for at least 1 cycle, so the 2 s timer restarts for every digit.
- State IN_LOAD:
  - Drive ram_addr=idx; next cycle go to IN_WAIT.
  - timer_en=1 from the first IN_LOAD until PASS or FAIL.
  - entry_valid in this state is dropped (button-shaped pulses cannot arrive 1 cycle apart).
- State IN_WAIT, on entry_valid:
  - entry_digit==ram_rdata: correct_cnt+1. If idx==len-1 go to PASS, otherwise idx+1 and go to IN_LOAD.
  - Mismatch: go to FAIL.
- timeout in IN_LOAD or IN_WAIT goes to FAIL. It wins over a simultaneous entry_valid, including a final correct entry.
- State PASS / FAIL:
  - Pulse round_pass or round_fail for 1 cycle, then return to IDLE.
  - Clear timer_en; hold correct_cnt until the next start.
- Abort in any state returns to IDLE on the next edge. It wins over a simultaneous start, tick, entry or timeout. No pass or fail pulse is emitted.
- Playback latency: start to first digit on display = 2 cycles; each digit is shown for exactly one tick_2s period.
- idx and len compare at ADDR_W+1 bits. seq_len=32 plays addresses 0..31 with no wrap. seq_len>32 is clamped to 32.
- disp_digit=BLANK in every state except SHOW.
- tick_2s and tick_100ms are ignored outside SHOW and GAP respectively.

Decomposition:
- Shared package orion_pkg holds:
  - the state enum (IDLE, FETCH, SHOW, GAP, IN_LOAD, IN_WAIT, PASS, FAIL);
  - BLANK_DIGIT=4'hF;
  - MAX_SEQ=32.
- Single flat module, with no sub-module. The FSM, idx counter and compare are all small.

Test Plan:
- seq_len=3, RAM={7,2,9}, tick_2s every 200 cycles and tick_100ms every 10 cycles -> disp_digit shows 7, F, 2, F, 9, F in order. Each digit lasts until its tick_2s; two_sec_en goes low between digits.
- Same round, then entries 7, 2, 9 -> correct_cnt steps 1, 2, 3; round_pass high for exactly 1 cycle; busy=0 afterwards.
- Entries 7, 4 -> round_fail pulse on the cycle after the second entry; correct_cnt=1; timer_en=0.
- timeout asserted in the same cycle as the final correct entry -> round_fail, not round_pass.
- abort during SHOW of digit 2, with start in the same cycle -> IDLE next cycle; disp_digit=F; no pass or fail pulse.
- seq_len=0 -> round_pass 2 cycles after start with no RAM reads. seq_len=32 -> ram_addr sweeps 0..31 and stops without wrapping to 0.
